// File: rtl/game_pkg.sv
// Shared screen geometry and object sizes for the obstacle and crash logic.
// No logic; constants and types only.
// Imported by the scroller, crash checker and drawer.
package game_pkg;

    localparam logic [9:0] SCREEN_W = 10'd320;
    localparam logic [9:0] SCREEN_H = 10'd240;
    localparam logic [9:0] PARK_X   = 10'd1000;
    localparam logic [9:0] PLANE_X  = 10'd100;
    localparam logic [9:0] OBJ_SZ   = 10'd16;
    localparam logic [9:0] MTN_W    = 10'd50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } lava_state_t;

endpackage

// File: rtl/obstacle_scroller_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, free-running random source.
// Latency: new value every clk cycle; output is the register itself.
// No backpressure: shifts every cycle, only reset stops it.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    // Shift left, feeding the tap XOR into bit 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= SEED;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/obstacle_scroller.sv
// Scrolls two mountains and one volcano lava blob once per frame tick.
// Latency: outputs update on the clk edge that samples frame_tick.
// Freezes while game_over is high; the LFSR keeps running regardless.
module obstacle_scroller
    import game_pkg::*;
#(
    parameter int unsigned SPEED     = 2,
    parameter int unsigned MIN_H     = 40,
    parameter int unsigned VOLCANO_X = 92,
    parameter int unsigned LAVA_V    = 4,
    parameter int unsigned LAVA_TOP  = 40
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       game_over,
    output logic [9:0] mountain1_x,
    output logic [9:0] mountain1_y,
    output logic [9:0] mountain2_x,
    output logic [9:0] mountain2_y,
    output logic [9:0] lava_x,
    output logic [9:0] lava_y,
    output logic       lava_active,
    output logic [7:0] score
);

    localparam logic [9:0] SPD        = 10'(SPEED);
    localparam logic [9:0] MTN_BASE   = SCREEN_H - 10'(MIN_H);
    localparam logic [9:0] LAVA_X0    = 10'(VOLCANO_X);
    localparam logic [9:0] LAVA_GND   = SCREEN_H - OBJ_SZ;
    localparam logic [9:0] LV         = 10'(LAVA_V);
    localparam logic [9:0] TOP        = 10'(LAVA_TOP);
    localparam logic [5:0] CNT_BASE   = 6'd32;

    logic [15:0]  rnd;
    logic         rnd_unused;
    logic         upd;
    logic         pass1;
    logic         pass2;
    logic [8:0]   score_sum;
    lava_state_t  state;
    logic [5:0]   countdown;

    lfsr16 #(.SEED(16'hACE1)) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .value  (rnd)
    );

    // Top nibble of the LFSR is not drawn from.
    assign rnd_unused = ^rnd[15:12];

    assign upd   = frame_tick & ~game_over;
    assign pass1 = mountain1_x < SPD;
    assign pass2 = mountain2_x < SPD;

    // Two respawns on one tick add two; the 9-bit sum exposes overflow.
    assign score_sum = {1'b0, score} + 9'(pass1) + 9'(pass2);

    // Mountains scroll left and respawn at the right edge; score counts respawns.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mountain1_x <= SCREEN_W;
            mountain1_y <= MTN_BASE;
            mountain2_x <= SCREEN_W + 10'd160;
            mountain2_y <= MTN_BASE;
            score       <= 8'd0;
        end else if (upd) begin
            if (pass1) begin
                mountain1_x <= SCREEN_W;
                mountain1_y <= MTN_BASE - {4'd0, rnd[5:0]};
            end else begin
                mountain1_x <= mountain1_x - SPD;
            end
            if (pass2) begin
                mountain2_x <= SCREEN_W;
                mountain2_y <= MTN_BASE - {4'd0, rnd[11:6]};
            end else begin
                mountain2_x <= mountain2_x - SPD;
            end
            score <= score_sum[8] ? 8'd255 : score_sum[7:0];
        end
    end

    // Lava FSM: wait a random countdown, rise to the apex, fall back to ground.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            lava_x      <= PARK_X;
            lava_y      <= 10'd0;
            lava_active <= 1'b0;
            countdown   <= CNT_BASE;
        end else if (upd) begin
            case (state)
                IDLE: begin
                    if (countdown == 6'd0) begin
                        state       <= RISE;
                        lava_x      <= LAVA_X0;
                        lava_y      <= LAVA_GND;
                        lava_active <= 1'b1;
                    end else begin
                        countdown <= countdown - 6'd1;
                    end
                end
                RISE: begin
                    if (lava_x < SPD) begin
                        state       <= IDLE;
                        lava_x      <= PARK_X;
                        lava_y      <= 10'd0;
                        lava_active <= 1'b0;
                        countdown   <= CNT_BASE + {1'b0, rnd[4:0]};
                    end else begin
                        lava_x <= lava_x - SPD;
                        // y - LV <= TOP, rearranged so y never underflows.
                        if (lava_y <= TOP + LV) begin
                            lava_y <= TOP;
                            state  <= FALL;
                        end else begin
                            lava_y <= lava_y - LV;
                        end
                    end
                end
                FALL: begin
                    if ((lava_x < SPD) || (lava_y + LV >= LAVA_GND)) begin
                        state       <= IDLE;
                        lava_x      <= PARK_X;
                        lava_y      <= 10'd0;
                        lava_active <= 1'b0;
                        countdown   <= CNT_BASE + {1'b0, rnd[4:0]};
                    end else begin
                        lava_x <= lava_x - SPD;
                        lava_y <= lava_y + LV;
                    end
                end
                default: begin
                    state       <= IDLE;
                    lava_x      <= PARK_X;
                    lava_y      <= 10'd0;
                    lava_active <= 1'b0;
                    countdown   <= CNT_BASE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller with a reference LFSR for random draws.
module tb_obstacle_scroller;

    logic       clk;
    logic       resetn;
    logic       frame_tick;
    logic       game_over;
    logic [9:0] mountain1_x;
    logic [9:0] mountain1_y;
    logic [9:0] mountain2_x;
    logic [9:0] mountain2_y;
    logic [9:0] lava_x;
    logic [9:0] lava_y;
    logic       lava_active;
    logic [7:0] score;

    int         vectors;
    int         miscompares;
    logic [15:0] mdl_lfsr;
    logic [15:0] last_draw;
    int         reload;
    int         tick_no;

    obstacle_scroller dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .game_over   (game_over),
        .mountain1_x (mountain1_x),
        .mountain1_y (mountain1_y),
        .mountain2_x (mountain2_x),
        .mountain2_y (mountain2_y),
        .lava_x      (lava_x),
        .lava_y      (lava_y),
        .lava_active (lava_active),
        .score       (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Fibonacci LFSR, taps 16/14/13/11, shifting left every cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) mdl_lfsr <= 16'hACE1;
        else         mdl_lfsr <= {mdl_lfsr[14:0], mdl_lfsr[15] ^ mdl_lfsr[13] ^ mdl_lfsr[12] ^ mdl_lfsr[10]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; applies n consecutive ticks and returns at a negedge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            last_draw  = mdl_lfsr;
            @(posedge clk);
            @(negedge clk);
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        frame_tick  = 1'b0;
        game_over   = 1'b0;
        last_draw   = 16'd0;
        resetn      = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_m1x", 32'(mountain1_x), 320);
        chk("rst_m1y", 32'(mountain1_y), 200);
        chk("rst_m2x", 32'(mountain2_x), 480);
        chk("rst_m2y", 32'(mountain2_y), 200);
        chk("rst_lx",  32'(lava_x), 1000);
        chk("rst_ly",  32'(lava_y), 0);
        chk("rst_la",  32'(lava_active), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_lfsr", 32'(dut.u_lfsr.value), 32'h0000ACE1);

        resetn = 1'b1;
        @(negedge clk);

        // Five ticks, then freeze with game_over rising on the same cycle as a tick
        tick(5);
        chk("t5_m1x", 32'(mountain1_x), 310);
        chk("t5_m2x", 32'(mountain2_x), 470);
        game_over = 1'b1;
        tick(21);
        chk("frz_m1x", 32'(mountain1_x), 310);
        chk("frz_m2x", 32'(mountain2_x), 470);
        chk("frz_m1y", 32'(mountain1_y), 200);
        chk("frz_score", 32'(score), 0);
        chk("frz_lx", 32'(lava_x), 1000);
        chk("frz_la", 32'(lava_active), 0);
        game_over = 1'b0;

        // Ten effective ticks
        tick(5);
        chk("t10_m1x", 32'(mountain1_x), 300);
        chk("t10_m2x", 32'(mountain2_x), 460);
        chk("t10_m1y", 32'(mountain1_y), 200);
        chk("t10_m2y", 32'(mountain2_y), 200);
        chk("t10_score", 32'(score), 0);
        chk("t10_lx", 32'(lava_x), 1000);

        // Countdown of 32 keeps lava parked through tick 32, launch on 33
        tick(22);
        chk("t32_la", 32'(lava_active), 0);
        chk("t32_lx", 32'(lava_x), 1000);
        tick(1);
        chk("t33_lx", 32'(lava_x), 92);
        chk("t33_ly", 32'(lava_y), 224);
        chk("t33_la", 32'(lava_active), 1);
        tick(1);
        chk("t34_lx", 32'(lava_x), 90);
        chk("t34_ly", 32'(lava_y), 220);

        // Rise 44 more: tick 78 at (2,44); tick 79 hits apex, pinned to 40 with x=0
        tick(44);
        chk("t78_lx", 32'(lava_x), 2);
        chk("t78_ly", 32'(lava_y), 44);
        tick(1);
        chk("t79_lx", 32'(lava_x), 0);
        chk("t79_ly", 32'(lava_y), 40);
        chk("t79_la", 32'(lava_active), 1);
        // First FALL tick exits on x < SPEED
        tick(1);
        chk("t80_lx", 32'(lava_x), 1000);
        chk("t80_ly", 32'(lava_y), 0);
        chk("t80_la", 32'(lava_active), 0);
        reload = 32 + int'(last_draw[4:0]);

        // Reloaded countdown: parked for `reload` ticks, launch on the next
        tick(reload);
        chk("cd_parked", 32'(lava_active), 0);
        tick(1);
        chk("cd_launch_la", 32'(lava_active), 1);
        chk("cd_launch_lx", 32'(lava_x), 92);
        tick_no = 81 + reload;

        // Mountain 1 reaches 0 at tick 160 and respawns on 161
        tick(160 - tick_no);
        chk("t160_m1x", 32'(mountain1_x), 0);
        chk("t160_score", 32'(score), 0);
        tick(1);
        chk("t161_m1x", 32'(mountain1_x), 320);
        chk("t161_m1y", 32'(mountain1_y), 32'(200 - int'(last_draw[5:0])));
        chk("t161_m1y_rng", 32'((mountain1_y >= 10'd137) && (mountain1_y <= 10'd200)), 1);
        chk("t161_score", 32'(score), 1);
        chk("t161_m2x", 32'(mountain2_x), 158);

        // Mountain 2 respawns on 241 drawing from bits 11:6
        tick(80);
        chk("t241_m2x", 32'(mountain2_x), 320);
        chk("t241_m2y", 32'(mountain2_y), 32'(200 - int'(last_draw[11:6])));
        chk("t241_score", 32'(score), 2);
        chk("t241_m1x", 32'(mountain1_x), 160);

        // Async reset while lava is rising
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        tick(36);
        chk("mid_la", 32'(lava_active), 1);
        chk("mid_ly", 32'(lava_y), 212);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst_lx", 32'(lava_x), 1000);
        chk("arst_ly", 32'(lava_y), 0);
        chk("arst_la", 32'(lava_active), 0);
        chk("arst_m1x", 32'(mountain1_x), 320);
        chk("arst_m2x", 32'(mountain2_x), 480);
        chk("arst_score", 32'(score), 0);
        chk("arst_lfsr", 32'(dut.u_lfsr.value), 32'h0000ACE1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Score saturation: 254 passes by tick 20607, 255 at 20608, held past 20688
        tick(20607);
        chk("sat_254", 32'(score), 254);
        tick(1);
        chk("sat_255", 32'(score), 255);
        tick(100);
        chk("sat_hold", 32'(score), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
